stimulus_conditioner: RTL

STIMULUS_CONDITIONER -- requirements
Module: stimulus_conditioner

---
 rtl/stimulus_conditioner.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/stimulus_conditioner.sv
// stimulus_conditioner
//   Turns N raw, asynchronous button/sensor levels into clean debounced
//   levels plus "pending event" bits that the consumer clears with a tick.
//
//   Parameters
//     N            number of stimulus channels
//     DEBOUNCE     cycles a changed (synchronised) sample must persist (2..256)
//     REPEAT_TICKS ticks between auto-repeat events (1..255)
//
//   Ports
//     clk          single clock, all state on the rising edge
//     rst          synchronous active-high reset
//     stim_raw     raw asynchronous levels, one bit per channel
//     tick         one-cycle consume strobe, clears every pending event
//     clr_ovr      clears all overrun flags
//     stim_level   debounced level per channel (registered)
//     stim_out     pending event per channel, held until a tick (registered)
//     event_any    combinational OR of stim_out
//     overrun      sticky per-channel "event lost" flag (registered)
//
//   Optional feature
//     Define STIM_AUTOREPEAT_EN to re-raise an event every REPEAT_TICKS ticks
//     while a channel stays pressed. Without it each press yields one event.

module stimulus_conditioner #(
  parameter int N            = 7,
  parameter int DEBOUNCE     = 16,
  parameter int REPEAT_TICKS = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] stim_raw,
  input  logic         tick,
  input  logic         clr_ovr,
  output logic [N-1:0] stim_level,
  output logic [N-1:0] stim_out,
  output logic         event_any,
  output logic [N-1:0] overrun
);

  // Counter only ever needs to reach DEBOUNCE-1 before it is cleared.
  localparam int            CW       = $clog2(DEBOUNCE + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE - 1);

  logic [N-1:0]  sync_a;
  logic [N-1:0]  sync_b;
  logic [CW-1:0] deb_cnt     [N];
  logic [CW-1:0] deb_cnt_nxt [N];
  logic [N-1:0]  level_nxt;
  logic [N-1:0]  rise;
  logic [N-1:0]  rep_fire;
  logic [N-1:0]  new_evt;
  logic [N-1:0]  out_nxt;
  logic [N-1:0]  ovr_nxt;

  // Debounce: a sample that disagrees with the current level must survive
  // DEBOUNCE consecutive edges; any agreeing sample restarts the count.
  always_comb begin
    level_nxt = stim_level;
    for (int ch = 0; ch < N; ch++) begin
      deb_cnt_nxt[ch] = deb_cnt[ch];
      if (sync_b[ch] == stim_level[ch]) begin
        deb_cnt_nxt[ch] = '0;
      end else if (deb_cnt[ch] == CNT_LAST) begin
        deb_cnt_nxt[ch] = '0;
        level_nxt[ch]   = sync_b[ch];
      end else begin
        deb_cnt_nxt[ch] = deb_cnt[ch] + CW'(1);
      end
    end
  end

  assign rise = level_nxt & ~stim_level;

`ifdef STIM_AUTOREPEAT_EN
  localparam int            RW       = (REPEAT_TICKS > 1) ? $clog2(REPEAT_TICKS) : 1;
  localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_TICKS - 1);

  logic [RW-1:0] rep_cnt     [N];
  logic [RW-1:0] rep_cnt_nxt [N];

  // Auto-repeat: count consume ticks while the debounced level is high and
  // raise a fresh event on every REPEAT_TICKS-th one; a released channel
  // starts over from zero.
  always_comb begin
    rep_fire = '0;
    for (int ch = 0; ch < N; ch++) begin
      rep_cnt_nxt[ch] = rep_cnt[ch];
      if (!stim_level[ch]) begin
        rep_cnt_nxt[ch] = '0;
      end else if (tick) begin
        if (rep_cnt[ch] == REP_LAST) begin
          rep_cnt_nxt[ch] = '0;
          rep_fire[ch]    = 1'b1;
        end else begin
          rep_cnt_nxt[ch] = rep_cnt[ch] + RW'(1);
        end
      end
    end
  end

  // Repeat counter state.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int ch = 0; ch < N; ch++) rep_cnt[ch] <= '0;
    end else begin
      for (int ch = 0; ch < N; ch++) rep_cnt[ch] <= rep_cnt_nxt[ch];
    end
  end
`else
  // No auto-repeat: a press produces exactly one event.
  always_comb begin
    rep_fire = '0;
  end
`endif

  // Event bookkeeping. A tick consumes everything pending, but an event
  // arriving on the same edge survives it. An event landing on a still
  // pending, unconsumed bit is lost and flagged; a new flag beats clr_ovr.
  always_comb begin
    new_evt = rise | rep_fire;
    out_nxt = tick ? new_evt : (stim_out | new_evt);
    ovr_nxt = (clr_ovr ? '0 : overrun) | (new_evt & stim_out & ~{N{tick}});
  end

  // All state registers; reset overrides tick and clr_ovr.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_a     <= '0;
      sync_b     <= '0;
      stim_level <= '0;
      stim_out   <= '0;
      overrun    <= '0;
      for (int ch = 0; ch < N; ch++) deb_cnt[ch] <= '0;
    end else begin
      sync_a     <= stim_raw;
      sync_b     <= sync_a;
      stim_level <= level_nxt;
      stim_out   <= out_nxt;
      overrun    <= ovr_nxt;
      for (int ch = 0; ch < N; ch++) deb_cnt[ch] <= deb_cnt_nxt[ch];
    end
  end

  assign event_any = |stim_out;

endmodule
